// File: rtl/up_counter_nbit.sv
// up_counter_nbit: parameterised up-counter with programmable limit, wrap or
// saturate mode, parallel load and clock prescaler.
//
// Parameters
//   WIDTH    : counter width in bits (>= 2)
//   PRESCALE : clock cycles per increment (>= 1); 1 = every enabled cycle
//
// Ports
//   i_clk        : rising-edge clock
//   i_rst_n      : asynchronous active-low reset
//   i_en         : count enable
//   i_clr        : synchronous clear to 0 (highest priority)
//   i_load       : synchronous parallel load of i_load_val
//   i_load_val   : value loaded when i_load = 1
//   i_limit      : terminal count, sampled every cycle
//   i_wrap       : 1 = wrap to 0 after limit, 0 = saturate at limit
//   o_count      : current count (registered)
//   o_at_limit   : combinational, o_count >= i_limit
//   o_wrap_pulse : registered one-cycle pulse while count shows the wrapped 0
//   o_sat        : registered, high while saturated
module up_counter_nbit #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_wrap,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_limit,
    output logic             o_wrap_pulse,
    output logic             o_sat
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StSat} state_e;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_count, w_count_d;
    logic [PreW-1:0]  r_pre, w_pre_d;
    logic             r_wrap_pulse, w_wrap_pulse_d;
    logic             w_tick;
    logic             w_at_limit;

    // Counts above the limit behave exactly like the limit itself.
    assign w_at_limit = (r_count >= i_limit);

    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_pre_d        = r_pre;
        w_wrap_pulse_d = 1'b0;
        w_tick         = 1'b0;

        if (i_clr) begin
            w_count_d = '0;
            w_pre_d   = '0;
            w_state_d = StIdle;
        end else if (i_load) begin
            w_count_d = i_load_val;
            w_pre_d   = '0;
            w_state_d = StIdle;
        end else begin
            case (r_state)
                // Entering RUN costs one edge with no increment; pre is kept.
                StIdle: begin
                    if (i_en) begin
                        w_state_d = StRun;
                    end
                end
                StRun: begin
                    if (!i_en) begin
                        w_state_d = StIdle;
                    end else if (r_pre != PreMax) begin
                        w_pre_d = r_pre + PreW'(1);
                    end else begin
                        w_pre_d = '0;
                        w_tick  = 1'b1;
                    end

                    if (w_tick) begin
                        if (!w_at_limit) begin
                            w_count_d = r_count + WIDTH'(1);
                        end else if (i_wrap) begin
                            w_count_d      = '0;
                            w_wrap_pulse_d = 1'b1;
                        end else begin
                            w_state_d = StSat;
                        end
                    end
                end
                // Saturated: frozen until clr or load.
                StSat: begin
                    w_state_d = StSat;
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_pre        <= '0;
            r_wrap_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_pre        <= w_pre_d;
            r_wrap_pulse <= w_wrap_pulse_d;
        end
    end

    assign o_count      = r_count;
    assign o_at_limit   = w_at_limit;
    assign o_wrap_pulse = r_wrap_pulse;
    assign o_sat        = (r_state == StSat);

endmodule

// File: tb/tb_up_counter_nbit.sv
// tb_up_counter_nbit: self-checking bench for up_counter_nbit.
// Two instances share stimulus: dut_a (PRESCALE=1) and dut_b (PRESCALE=3).
// Directed vectors come from a table of hand-derived expectations; random
// stimulus is compared against a behavioural model of both instances.
module tb_up_counter_nbit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         en, clr, load, wrap;
    logic [W-1:0] load_val, limit;

    logic [W-1:0] a_count, b_count;
    logic         a_at, a_wp, a_sat;
    logic         b_at, b_wp, b_sat;

    int errors = 0;
    int checks = 0;

    up_counter_nbit #(.WIDTH(W), .PRESCALE(1)) dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_clr        (clr),
        .i_load       (load),
        .i_load_val   (load_val),
        .i_limit      (limit),
        .i_wrap       (wrap),
        .o_count      (a_count),
        .o_at_limit   (a_at),
        .o_wrap_pulse (a_wp),
        .o_sat        (a_sat)
    );

    up_counter_nbit #(.WIDTH(W), .PRESCALE(3)) dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_clr        (clr),
        .i_load       (load),
        .i_load_val   (load_val),
        .i_limit      (limit),
        .i_wrap       (wrap),
        .o_count      (b_count),
        .o_at_limit   (b_at),
        .o_wrap_pulse (b_wp),
        .o_sat        (b_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a count, a prescale phase, and two flags.
    typedef struct {
        int cnt;
        int phase;
        bit running;
        bit saturated;
        bit wp;
    } model_t;

    model_t ma, mb;

    function automatic model_t model_reset();
        model_t m;
        m.cnt = 0; m.phase = 0; m.running = 0; m.saturated = 0; m.wp = 0;
        return m;
    endfunction

    function automatic model_t model_step(model_t m, int ps, bit c, bit l, int lv, int lim,
                                          bit wr, bit e);
        model_t n;
        n = m;
        n.wp = 0;
        if (c) begin
            n = model_reset();
        end else if (l) begin
            n = model_reset();
            n.cnt = lv;
        end else if (m.saturated) begin
            // frozen
        end else if (!m.running) begin
            n.running = e;
        end else if (!e) begin
            n.running = 0;
        end else begin
            n.phase = (m.phase + 1) % ps;
            if (m.phase == ps - 1) begin
                if (m.cnt < lim) n.cnt = m.cnt + 1;
                else if (wr) begin n.cnt = 0; n.wp = 1; end
                else begin n.saturated = 1; n.running = 0; end
            end
        end
        return n;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_models(input string tag);
        cmp({tag, " a.count"}, int'(a_count), ma.cnt);
        cmp({tag, " a.at_limit"}, int'(a_at), int'(ma.cnt >= int'(limit)));
        cmp({tag, " a.wrap_pulse"}, int'(a_wp), int'(ma.wp));
        cmp({tag, " a.sat"}, int'(a_sat), int'(ma.saturated));
        cmp({tag, " b.count"}, int'(b_count), mb.cnt);
        cmp({tag, " b.at_limit"}, int'(b_at), int'(mb.cnt >= int'(limit)));
        cmp({tag, " b.wrap_pulse"}, int'(b_wp), int'(mb.wp));
        cmp({tag, " b.sat"}, int'(b_sat), int'(mb.saturated));
    endtask

    // One clock edge: inputs are stable here, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        ma = model_step(ma, 1, clr, load, int'(load_val), int'(limit), wrap, en);
        mb = model_step(mb, 3, clr, load, int'(load_val), int'(limit), wrap, en);
        #1;
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input int lim, input bit wr,
                         input bit e);
        clr = c; load = l; load_val = W'(lv); limit = W'(lim); wrap = wr; en = e;
    endtask

    typedef struct {
        bit clr, load;
        int lv, lim;
        bit wr, en;
        int e_cnt;
        bit e_sat, e_wp, e_at;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        ma = model_reset();
        mb = model_reset();
        #2;
        // Reset state, with at_limit following the live limit input.
        cmp("rst count", int'(a_count), 0);
        cmp("rst sat", int'(a_sat), 0);
        cmp("rst wrap_pulse", int'(a_wp), 0);
        cmp("rst at_limit lim0", int'(a_at), 1);
        limit = 4'd3;
        #1;
        cmp("rst at_limit lim3", int'(a_at), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Hand-derived vectors for dut_a (PRESCALE=1).
        //           clr ld lv lim wr en  cnt sat wp at
        vecs.push_back('{0, 0, 0, 3, 1, 1, 0, 0, 0, 0}); // IDLE->RUN, no increment
        vecs.push_back('{0, 0, 0, 3, 1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 3, 1, 1, 2, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 3, 1, 1, 3, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 3, 1, 1, 0, 0, 1, 0}); // wrap
        vecs.push_back('{0, 0, 0, 3, 1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 3, 0, 1, 2, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 3, 0, 1, 3, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 3, 0, 1, 3, 1, 0, 1}); // saturate
        vecs.push_back('{0, 0, 0, 3, 1, 0, 3, 1, 0, 1}); // SAT ignores en/wrap
        vecs.push_back('{0, 0, 0, 1, 1, 1, 3, 1, 0, 1});
        vecs.push_back('{1, 0, 0, 3, 0, 1, 0, 0, 0, 0}); // clr -> IDLE
        vecs.push_back('{0, 0, 0, 3, 0, 1, 0, 0, 0, 0}); // IDLE->RUN
        vecs.push_back('{0, 0, 0, 3, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 12, 9, 1, 1, 12, 0, 0, 1}); // load above limit
        vecs.push_back('{0, 0, 0, 9, 1, 1, 12, 0, 0, 1});  // IDLE->RUN
        vecs.push_back('{0, 0, 0, 9, 1, 1, 0, 0, 1, 0});   // treated as at limit: wrap
        vecs.push_back('{0, 0, 0, 9, 1, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 1, 7, 9, 1, 0, 7, 0, 0, 0});
        vecs.push_back('{1, 1, 5, 9, 1, 1, 0, 0, 0, 0});   // clr beats load
        vecs.push_back('{0, 0, 0, 15, 1, 1, 0, 0, 0, 0});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clr, vecs[i].load, vecs[i].lv, vecs[i].lim, vecs[i].wr, vecs[i].en);
            step();
            cmp($sformatf("vec%0d count", i), int'(a_count), vecs[i].e_cnt);
            cmp($sformatf("vec%0d sat", i), int'(a_sat), int'(vecs[i].e_sat));
            cmp($sformatf("vec%0d wrap_pulse", i), int'(a_wp), int'(vecs[i].e_wp));
            cmp($sformatf("vec%0d at_limit", i), int'(a_at), int'(vecs[i].e_at));
            check_models($sformatf("vec%0d", i));
        end

        // Full 0..15 rollover on dut_a: period 16, pulse only with the wrapped 0.
        drive(1, 0, 0, 15, 1, 1);
        step();
        drive(0, 0, 0, 15, 1, 1);
        step();
        for (int i = 1; i <= 32; i++) begin
            step();
            cmp("roll count", int'(a_count), i % 16);
            cmp("roll wrap_pulse", int'(a_wp), int'((i % 16) == 0));
        end
        check_models("roll");

        // Prescale 3 on dut_b: freeze mid-prescale, then resume.
        drive(1, 0, 0, 15, 1, 1);
        step();
        drive(0, 0, 0, 15, 1, 1);
        step();                               // IDLE->RUN
        step(); step();
        cmp("ps before tick", int'(b_count), 0);
        step();
        cmp("ps first tick", int'(b_count), 1);
        step();                               // one prescale cycle in
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            cmp("ps frozen", int'(b_count), 1);
        end
        en = 1'b1;
        step();                               // IDLE->RUN
        step();
        cmp("ps resume wait", int'(b_count), 1);
        step();
        cmp("ps resume tick", int'(b_count), 2);
        check_models("ps");

        // Asynchronous reset mid-count and mid-prescale.
        drive(0, 1, 7, 15, 1, 1);
        step();
        drive(0, 0, 0, 15, 1, 1);
        step(); step();
        #3;
        rst_n = 1'b0;
        #1;
        ma = model_reset();
        mb = model_reset();
        cmp("arst a.count", int'(a_count), 0);
        cmp("arst b.count", int'(b_count), 0);
        cmp("arst b.wrap_pulse", int'(b_wp), 0);
        cmp("arst b.sat", int'(b_sat), 0);
        #2;
        rst_n = 1'b1;
        step();                               // IDLE->RUN
        step(); step();
        cmp("arst b.hold", int'(b_count), 0);
        step();
        cmp("arst b.first", int'(b_count), 1);
        check_models("arst");

        // Randomised stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            clr  = ($urandom_range(0, 39) == 0);
            load = ($urandom_range(0, 29) == 0);
            load_val = W'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) limit = W'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) wrap = $urandom_range(0, 1) != 0;
            en = ($urandom_range(0, 9) < 8);
            step();
            check_models($sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
